pc_fetch_ctrl: RTL

//  Instruction-fetch initiator. Owns the architectural PC and drives the ibus request side.

---
 rtl/pc_fetch_ctrl_pkg.sv | 27 ++
 rtl/pc_fetch_buf.sv | 45 ++++
 rtl/pc_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_ctrl_pkg
// Brief   : Shared types and constants for the instruction-fetch initiator.
// Revision: 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

   typedef logic [31:0] u32_t;
   typedef logic [63:0] u64_t;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam u64_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
   localparam u64_t PC_STEP_DEFAULT  = 64'd4;
   localparam u32_t NOP_INSTR        = 32'h0000_0013;

   function automatic logic pc_aligned(input logic [1:0] pc_lsb);
      return (pc_lsb == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_buf
// Brief   : One-entry valid/instr/pc holding register with flush.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_buf
   import pc_fetch_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_flush,
   input  u32_t i_instr,
   input  u64_t i_pc,
   output logic o_valid,
   output u32_t o_instr,
   output u64_t o_pc
);

   logic r_valid;
   u32_t r_instr;
   u64_t r_pc;

   // Flush wins over load so a redirect can never let a stale pair through.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_ctrl
// Brief   : Owns the architectural PC, issues ibus fetches, delivers
//           {instr, pc} pairs and discards responses made stale by redirects.
//           Optional PC_FETCH_PREFETCH_EN adds a one-entry prefetch slot.
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter u64_t PC_RESET = PC_RESET_DEFAULT,
   parameter u64_t PC_STEP  = PC_STEP_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc
);

   fetch_state_t r_state;
   u64_t         r_pc;
   logic         r_drop;
   logic         r_stale;

   u64_t w_pc_seq;
   logic w_aligned;
   logic w_req_main;
   logic w_out_load;
   logic w_out_flush;
   u32_t w_out_instr;
   u64_t w_out_pc;
   logic w_data_expected;

   assign w_pc_seq   = r_pc + PC_STEP;
   assign w_aligned  = pc_aligned(r_pc[1:0]);
   assign w_req_main = (r_state == REQ) && w_aligned && !reset;

`ifdef PC_FETCH_PREFETCH_EN
   logic r_pf_pend;
   logic r_pf_req;
   logic w_pf_issue;
   logic w_pf_accept;
   logic w_pf_data;
   logic w_pf_load;
   logic w_pf_flush;
   logic w_pf_valid;
   u32_t w_pf_instr;
   u64_t w_pf_pc;

   // Once a prefetch request is raised it stays up until accepted, even across stall release.
   assign w_pf_issue  = (r_state == HOLD) && !r_pf_pend && !w_pf_valid &&
                        pc_aligned(w_pc_seq[1:0]) && (stall || r_pf_req) && !reset;
   assign w_pf_accept = w_pf_issue && iresp_addr_ok;
   assign w_pf_data   = r_pf_pend && iresp_data_ok;

   assign ireq_valid      = w_req_main || w_pf_issue;
   assign ireq_addr       = (r_state == HOLD) ? w_pc_seq : r_pc;
   assign w_data_expected = (r_state == WAIT) || r_pf_pend;

   pc_fetch_buf u_pf_buf (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_pf_load),
      .i_flush (w_pf_flush),
      .i_instr (iresp_data),
      .i_pc    (w_pc_seq),
      .o_valid (w_pf_valid),
      .o_instr (w_pf_instr),
      .o_pc    (w_pf_pc)
   );
`else
   assign ireq_valid      = w_req_main;
   assign ireq_addr       = r_pc;
   assign w_data_expected = (r_state == WAIT);
`endif

   always_comb begin
      w_out_load  = 1'b0;
      w_out_flush = redirect;
      w_out_instr = iresp_data;
      w_out_pc    = r_pc;
`ifdef PC_FETCH_PREFETCH_EN
      w_pf_load   = 1'b0;
      w_pf_flush  = redirect;
`endif
      if (!redirect) begin
         case (r_state)
            REQ: begin
               if (!w_aligned) begin
                  w_out_load  = 1'b1;
                  w_out_instr = NOP_INSTR;
               end
            end
            WAIT: begin
               if (iresp_data_ok && !r_drop) w_out_load = 1'b1;
            end
            HOLD: begin
`ifdef PC_FETCH_PREFETCH_EN
               if (stall) begin
                  w_pf_load = w_pf_data;
               end else if (w_pf_valid) begin
                  w_out_load  = 1'b1;
                  w_out_instr = w_pf_instr;
                  w_out_pc    = w_pf_pc;
                  w_pf_flush  = 1'b1;
               end else if (w_pf_data) begin
                  w_out_load = 1'b1;
                  w_out_pc   = w_pc_seq;
               end else begin
                  w_out_flush = 1'b1;
               end
`else
               w_out_flush = !stall;
`endif
            end
            default: ;
         endcase
      end
   end

   pc_fetch_buf u_out_buf (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_out_load),
      .i_flush (w_out_flush),
      .i_instr (w_out_instr),
      .i_pc    (w_out_pc),
      .o_valid (out_valid),
      .o_instr (out_instr),
      .o_pc    (out_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= REQ;
         r_pc    <= PC_RESET;
         r_drop  <= 1'b0;
         // Remember that one response may still arrive for a request killed by reset.
`ifdef PC_FETCH_PREFETCH_EN
         r_stale   <= (r_stale || (r_state == WAIT) || r_pf_pend) && !iresp_data_ok;
         r_pf_pend <= 1'b0;
         r_pf_req  <= 1'b0;
`else
         r_stale   <= (r_stale || (r_state == WAIT)) && !iresp_data_ok;
`endif
      end else begin
         if (iresp_data_ok) r_stale <= 1'b0;
         case (r_state)
            REQ: begin
               if (redirect) begin
                  r_pc <= redirect_pc;
                  if (w_req_main && iresp_addr_ok) begin
                     r_state <= WAIT;
                     r_drop  <= 1'b1;
                  end
               end else if (!w_aligned) begin
                  r_state <= HOLD;
               end else if (iresp_addr_ok) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  r_pc <= redirect_pc;
                  if (iresp_data_ok) begin
                     r_state <= REQ;
                     r_drop  <= 1'b0;
                  end else begin
                     r_drop  <= 1'b1;
                  end
               end else if (iresp_data_ok) begin
                  r_drop  <= 1'b0;
                  r_state <= r_drop ? REQ : HOLD;
               end
            end
            HOLD: begin
`ifdef PC_FETCH_PREFETCH_EN
               r_pf_req <= 1'b0;
               if (redirect) begin
                  r_pc      <= redirect_pc;
                  r_pf_pend <= 1'b0;
                  if ((r_pf_pend && !iresp_data_ok) || w_pf_accept) begin
                     r_state <= WAIT;
                     r_drop  <= 1'b1;
                  end else begin
                     r_state <= REQ;
                  end
               end else if (stall) begin
                  if (w_pf_data)        r_pf_pend <= 1'b0;
                  else if (w_pf_accept) r_pf_pend <= 1'b1;
                  r_pf_req <= w_pf_issue && !iresp_addr_ok;
               end else begin
                  r_pc      <= w_pc_seq;
                  r_pf_pend <= 1'b0;
                  if (w_pf_valid || w_pf_data)        r_state <= HOLD;
                  else if (r_pf_pend || w_pf_accept)  r_state <= WAIT;
                  else                                r_state <= REQ;
               end
`else
               if (redirect) begin
                  r_pc    <= redirect_pc;
                  r_state <= REQ;
               end else if (!stall) begin
                  r_pc    <= w_pc_seq;
                  r_state <= REQ;
               end
`endif
            end
            default: r_state <= REQ;
         endcase
      end
   end

   a_data_ok_protocol: assert property (@(posedge clk) disable iff (reset)
      iresp_data_ok |-> (w_data_expected || r_stale));

endmodule
`default_nettype wire
